// File: rtl/draw_pkg.sv
// Shared constants and FSM state type for the per-object sprite pixel engines.
package draw_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOR_W  = 3;
  localparam int CNT_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ERASE,
    ST_DRAW,
    ST_FIN
  } state_t;
endpackage

// File: rtl/rect_scan.sv
// Raster scan over a WIDTH x HEIGHT rectangle: cx runs fastest, cy steps on cx wrap.
module rect_scan
  import draw_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int HEIGHT = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] cx,
  output logic [CNT_W-1:0] cy,
  output logic             last_pixel
);
  localparam logic [CNT_W-1:0] CX_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CY_LAST = CNT_W'(HEIGHT - 1);

  assign last_pixel = (cx == CX_LAST) && (cy == CY_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cx <= '0;
      cy <= '0;
    end else if (clear) begin
      cx <= '0;
      cy <= '0;
    end else if (enable) begin
      if (cx == CX_LAST) begin
        cx <= '0;
        cy <= (cy == CY_LAST) ? '0 : cy + 1'b1;
      end else begin
        cx <= cx + 1'b1;
      end
    end
  end
endmodule

// File: rtl/sprite_drawer.sv
// Sprite pixel engine: erases the previous rectangle, then paints the new one,
// emitting one registered pixel per clock with on-screen clipping.
module sprite_drawer
  import draw_pkg::*;
#(
  parameter int                 WIDTH    = 4,
  parameter int                 HEIGHT   = 4,
  parameter logic [COLOR_W-1:0] BG_COLOR = 3'b000,
  parameter int                 X_MAX    = SCREEN_W,
  parameter int                 Y_MAX    = SCREEN_H
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [X_W-1:0]     new_x,
  input  logic [Y_W-1:0]     new_y,
  input  logic [COLOR_W-1:0] new_color,
  output logic [X_W-1:0]     x_out,
  output logic [Y_W-1:0]     y_out,
  output logic [COLOR_W-1:0] color_out,
  output logic               plot,
  output logic               busy,
  output logic               done
);
  localparam logic [X_W:0] X_LIM = (X_W + 1)'(X_MAX);
  localparam logic [Y_W:0] Y_LIM = (Y_W + 1)'(Y_MAX);

  state_t state, state_next;

  logic [X_W-1:0]     cur_x, old_x, base_x;
  logic [Y_W-1:0]     cur_y, old_y, base_y;
  logic [COLOR_W-1:0] cur_color;
  logic               old_valid;
  logic               scan_clear, scan_en, last_pixel;
  logic [CNT_W-1:0]   cx, cy;
  logic [X_W:0]       px;
  logic [Y_W:0]       py;
  logic               on_screen;

  rect_scan #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT)
  ) u_scan (
    .clk       (clk),
    .resetn    (resetn),
    .clear     (scan_clear),
    .enable    (scan_en),
    .cx        (cx),
    .cy        (cy),
    .last_pixel(last_pixel)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    scan_clear = 1'b0;
    scan_en    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = old_valid ? ST_ERASE : ST_DRAW;
          scan_clear = 1'b1;
        end
      end
      ST_ERASE: begin
        scan_en = 1'b1;
        if (last_pixel) begin
          state_next = ST_DRAW;
          scan_clear = 1'b1;
        end
      end
      ST_DRAW: begin
        scan_en = 1'b1;
        if (last_pixel) state_next = ST_FIN;
      end
      ST_FIN: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Erase walks the old rectangle; draw walks the newly latched one.
  assign base_x    = (state == ST_ERASE) ? old_x : cur_x;
  assign base_y    = (state == ST_ERASE) ? old_y : cur_y;
  assign px        = (X_W + 1)'(base_x) + (X_W + 1)'(cx);
  assign py        = (Y_W + 1)'(base_y) + (Y_W + 1)'(cy);
  assign on_screen = (px < X_LIM) && (py < Y_LIM);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_out     <= '0;
      y_out     <= '0;
      color_out <= '0;
      plot      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cur_x     <= '0;
      cur_y     <= '0;
      cur_color <= '0;
      old_x     <= '0;
      old_y     <= '0;
      old_valid <= 1'b0;
    end else begin
      plot <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            cur_x     <= new_x;
            cur_y     <= new_y;
            cur_color <= new_color;
          end
        end
        ST_ERASE, ST_DRAW: begin
          x_out     <= px[X_W-1:0];
          y_out     <= py[Y_W-1:0];
          color_out <= (state == ST_ERASE) ? BG_COLOR : cur_color;
          plot      <= on_screen;
          busy      <= 1'b1;
        end
        ST_FIN: begin
          done      <= 1'b1;
          old_x     <= cur_x;
          old_y     <= cur_y;
          old_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sprite_drawer.sv
// Bench for sprite_drawer: a queue-based pixel-stream model checked every cycle,
// plus directed runs with hand-computed timing and pixel expectations.
module tb_sprite_drawer;
  localparam int W = 4;
  localparam int H = 4;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       p;
    logic       b;
    logic       d;
  } px_t;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [7:0] new_x = '0;
  logic [6:0] new_y = '0;
  logic [2:0] new_color = '0;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] color_out;
  logic       plot, busy, done;

  int checks = 0;
  int errors = 0;

  sprite_drawer dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .new_x    (new_x),
    .new_y    (new_y),
    .new_color(new_color),
    .x_out    (x_out),
    .y_out    (y_out),
    .color_out(color_out),
    .plot     (plot),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  function automatic px_t mk(input int x, input int y, input int c, input bit p, input bit b, input bit d);
    px_t r;
    r.x = 8'(x); r.y = 7'(y); r.c = 3'(c); r.p = p; r.b = b; r.d = d;
    return r;
  endfunction

  function automatic px_t cur_out();
    return {x_out, y_out, color_out, plot, busy, done};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a start seen with nothing pending expands into the list of per-cycle outputs.
  px_t        exp_q[$];
  px_t        exp_cur = '0;
  bit         m_valid = 1'b0;
  logic [7:0] m_old_x = '0;
  logic [6:0] m_old_y = '0;
  bit         was_empty;

  task automatic push_rect(input int bx, input int by, input int c);
    for (int j = 0; j < H; j++)
      for (int i = 0; i < W; i++)
        exp_q.push_back(mk(bx + i, by + j, c, (bx + i < 160) && (by + j < 120), 1'b1, 1'b0));
  endtask

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      exp_q.delete();
      exp_cur = '0;
      m_valid = 1'b0;
    end else begin
      was_empty = (exp_q.size() == 0);
      if (!was_empty) exp_cur = exp_q.pop_front();
      else begin
        exp_cur.p = 1'b0; exp_cur.b = 1'b0; exp_cur.d = 1'b0;
      end
      if (was_empty && start) begin
        if (m_valid) push_rect(int'(m_old_x), int'(m_old_y), 0);
        push_rect(int'(new_x), int'(new_y), int'(new_color));
        exp_q.push_back(mk(int'(new_x) + W - 1, int'(new_y) + H - 1, int'(new_color), 1'b0, 1'b0, 1'b1));
        m_old_x = new_x;
        m_old_y = new_y;
        m_valid = 1'b1;
      end
    end
  end

  always @(negedge clk) chk("stream", 32'(cur_out()), 32'(exp_cur));

  px_t log_s[0:63];
  int  done_n, busy_n, plot_n;

  task automatic run(input int x, input int y, input int c, input int poke_at, input int rst_at);
    @(negedge clk);
    new_x = 8'(x); new_y = 7'(y); new_color = 3'(c); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    new_x = 8'($urandom); new_y = 7'($urandom); new_color = 3'($urandom);
    done_n = 0; busy_n = 0; plot_n = 0;
    for (int n = 1; n <= 60 && done_n == 0; n++) begin
      @(posedge clk); #1;
      log_s[n] = cur_out();
      if (busy) busy_n++;
      if (plot) plot_n++;
      if (done) done_n = n;
      if (n == poke_at) begin
        new_x = 8'd50; new_y = 7'd50; start = 1'b1;
      end else if (n == poke_at + 1) begin
        start = 1'b0;
      end
      if (n == rst_at) begin
        resetn = 1'b0;
        #1;
        chk("reset_mid", 32'(cur_out()), 32'(0));
        @(negedge clk);
        resetn = 1'b1;
        return;
      end
    end
    if (done_n == 0) chk("done_timeout", 32'(0), 32'(1));
  endtask

  int  low_n, rises;
  bit  fell, prev_busy;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    chk("reset_state", 32'(cur_out()), 32'(0));

    // 1: first draw goes straight to DRAW
    run(10, 20, 4, 0, 0);
    chk("t1_done", 32'(done_n), 32'(17));
    chk("t1_busy", 32'(busy_n), 32'(16));
    chk("t1_plot", 32'(plot_n), 32'(16));
    chk("t1_first", 32'(log_s[1]), 32'(mk(10, 20, 4, 1, 1, 0)));
    chk("t1_last", 32'(log_s[16]), 32'(mk(13, 23, 4, 1, 1, 0)));
    repeat (2) @(posedge clk);
    #1 chk("t1_hold", 32'({x_out, y_out, color_out}), 32'({8'd13, 7'd23, 3'd4}));

    // 2: redraw erases the old rectangle first
    run(11, 20, 4, 0, 0);
    chk("t2_done", 32'(done_n), 32'(33));
    chk("t2_busy", 32'(busy_n), 32'(32));
    chk("t2_erase0", 32'(log_s[1]), 32'(mk(10, 20, 0, 1, 1, 0)));
    chk("t2_draw0", 32'(log_s[17]), 32'(mk(11, 20, 4, 1, 1, 0)));
    chk("t2_last", 32'(log_s[32]), 32'(mk(14, 23, 4, 1, 1, 0)));

    // 3: clipping at the bottom-right corner
    run(158, 118, 2, 0, 0);
    chk("t3_done", 32'(done_n), 32'(33));
    chk("t3_plot", 32'(plot_n), 32'(20));
    chk("t3_draw0", 32'(log_s[17]), 32'(mk(158, 118, 2, 1, 1, 0)));
    chk("t3_clipx", 32'(log_s[19]), 32'(mk(160, 118, 2, 0, 1, 0)));
    chk("t3_corner", 32'(log_s[32]), 32'(mk(161, 121, 2, 0, 1, 0)));

    // 4: start pulsed mid-DRAW is dropped
    run(30, 40, 5, 20, 0);
    chk("t4_done", 32'(done_n), 32'(33));
    run(60, 60, 1, 0, 0);
    chk("t4_old", 32'(log_s[1]), 32'(mk(30, 40, 0, 1, 1, 0)));

    // 5: reset on erase pixel 5, next draw skips the erase
    run(70, 70, 3, 0, 6);
    run(80, 80, 6, 0, 0);
    chk("t5_done", 32'(done_n), 32'(17));
    chk("t5_first", 32'(log_s[1]), 32'(mk(80, 80, 6, 1, 1, 0)));

    // 6: start held high; busy drops for the FIN cycle plus one IDLE cycle
    @(negedge clk);
    new_x = 8'd90; new_y = 7'd90; new_color = 3'd7; start = 1'b1;
    low_n = 0; rises = 0; fell = 1'b0; prev_busy = 1'b0;
    for (int n = 0; n < 200 && rises < 2; n++) begin
      @(posedge clk); #1;
      if (busy && !prev_busy) rises++;
      if (!busy && prev_busy) fell = 1'b1;
      if (!busy && fell && rises == 1) low_n++;
      prev_busy = busy;
    end
    start = 1'b0;
    chk("t6_rises", 32'(rises), 32'(2));
    chk("t6_gap", 32'(low_n), 32'(2));
    done_n = 0;
    for (int n = 0; n < 60 && done_n == 0; n++) begin
      @(posedge clk); #1;
      if (done) done_n = 1;
    end
    chk("t6_done", 32'(done_n), 32'(1));

    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
